// File: rtl/fetch_unit.sv
// Instruction fetch unit: word-aligned PC register feeding a small fetch FIFO, with redirect flush.
// Optional misaligned-redirect flag is built when FETCH_MISALIGN_CHK_EN is defined.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [ADDR_WIDTH-1:0] out_pc_plus4
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic                  misalign_err
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]         DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  logic [ADDR_WIDTH-1:0]    pc_q, pc_d;
  logic [CW-1:0]            count_q, count_d;
  logic [PW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  entry_t [FIFO_DEPTH-1:0]  fifo_q, fifo_d;
  logic                     enq, deq;

  assign instr_addr   = pc_q;
  assign out_valid    = (count_q != '0);
  assign out_instr    = fifo_q[rptr_q].instr;
  assign out_pc       = fifo_q[rptr_q].pc;
  assign out_pc_plus4 = fifo_q[rptr_q].pc + PC_STEP;

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    fifo_d  = fifo_q;
    deq     = out_valid & out_ready;
    enq     = !redirect_valid & ((count_q < DEPTH_C) | deq);
    if (redirect_valid) begin
      // Flush wins over everything; a same-cycle deq is still consumed by decode.
      pc_d    = redirect_pc & ALIGN_MASK;
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (enq) begin
        fifo_d[wptr_q] = '{instr: instr, pc: pc_q};
        wptr_d         = wptr_q + PW'(1);
        pc_d           = pc_q + PC_STEP;
      end
      if (deq) rptr_d = rptr_q + PW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC & ALIGN_MASK;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Payload storage carries no reset; it is only observed while out_valid=1.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = redirect_valid & (redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end

  assign misalign_err = misalign_q;
`else
  // Without the checker, low target bits are simply masked off by ALIGN_MASK.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory word[i]=i, checks streaming, backpressure, redirect, wrap and reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_addr;
  logic [31:0] instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  fetch_unit #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_addr    (instr_addr),
    .instr         (instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_pc_plus4  (out_pc_plus4)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .misalign_err  (misalign_err)
`endif
  );

  // Instruction memory: word i holds value i.
  assign instr = {2'b00, instr_addr[31:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #2;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_addr", 64'(instr_addr), 64'h0);

    // Streaming from reset
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("s0_valid", 64'(out_valid), 64'd1);
    check("s0_pc", 64'(out_pc), 64'h0);
    check("s0_instr", 64'(out_instr), 64'd0);
    check("s0_pc4", 64'(out_pc_plus4), 64'h4);
    check("s0_addr", 64'(instr_addr), 64'h4);
    tick();
    check("s1_pc", 64'(out_pc), 64'h4);
    check("s1_instr", 64'(out_instr), 64'd1);
    check("s1_addr", 64'(instr_addr), 64'h8);
    tick();
    check("s2_instr", 64'(out_instr), 64'd2);
    check("s2_pc4", 64'(out_pc_plus4), 64'hC);

    // Asynchronous reset between edges, then backpressure
    #3;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_addr", 64'(instr_addr), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_addr", 64'(instr_addr), 64'h8);
    check("bp_pc", 64'(out_pc), 64'h0);
    check("bp_instr", 64'(out_instr), 64'd0);
    out_ready = 1'b1;
    tick();
    check("bp1_pc", 64'(out_pc), 64'h4);
    check("bp1_valid", 64'(out_valid), 64'd1);
    tick();
    check("bp2_pc", 64'(out_pc), 64'h8);
    check("bp2_instr", 64'(out_instr), 64'd2);

    // Redirect while full, deq taken in the same cycle
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    check("rd_valid", 64'(out_valid), 64'd0);
    check("rd_addr", 64'(instr_addr), 64'h100);
    tick();
    check("rd1_valid", 64'(out_valid), 64'd1);
    check("rd1_pc", 64'(out_pc), 64'h100);
    check("rd1_instr", 64'(out_instr), 64'h40);
    tick();
    check("rd2_pc", 64'(out_pc), 64'h104);

    // Address wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    check("wr_valid", 64'(out_valid), 64'd0);
    tick();
    check("wr0_pc", 64'(out_pc), 64'hFFFF_FFF8);
    check("wr0_instr", 64'(out_instr), 64'h3FFF_FFFE);
    tick();
    check("wr1_pc", 64'(out_pc), 64'hFFFF_FFFC);
    check("wr1_pc4", 64'(out_pc_plus4), 64'h0);
    check("wr1_addr", 64'(instr_addr), 64'h0);
    tick();
    check("wr2_pc", 64'(out_pc), 64'h0);

    // Back-to-back redirects keep the buffer empty
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    check("bb0_valid", 64'(out_valid), 64'd0);
    check("bb0_addr", 64'(instr_addr), 64'h200);
    redirect_pc = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    check("bb1_valid", 64'(out_valid), 64'd0);
    check("bb1_addr", 64'(instr_addr), 64'h300);
    tick();
    check("bb2_pc", 64'(out_pc), 64'h300);

    // Misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    check("ma_addr", 64'(instr_addr), 64'h100);
`ifdef FETCH_MISALIGN_CHK_EN
    check("ma_err_hi", 64'(misalign_err), 64'd1);
`endif
    tick();
    check("ma_pc", 64'(out_pc), 64'h100);
`ifdef FETCH_MISALIGN_CHK_EN
    check("ma_err_lo", 64'(misalign_err), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
